// File: rtl/mdu_sequencer.sv
// Iterative multiply/divide unit owning the HI/LO pair: shift-add multiplier and
// restoring divider, n iterations plus one sign-fixup cycle per operation.
module mdu_sequencer #(
    parameter int n = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [1:0]   op,
    input  logic [n-1:0] a,
    input  logic [n-1:0] b,
    input  logic         mthi,
    input  logic         mtlo,
    input  logic [n-1:0] wd,
    output logic [n-1:0] hi,
    output logic [n-1:0] lo,
    output logic         busy,
    output logic         done,
    output logic         div_by_zero
);
    localparam int CW = (n > 1) ? $clog2(n) : 1;

    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

    state_t         state_q;
    logic [CW-1:0]  cnt_q;
    logic           is_div_q, neg_res_q, neg_rem_q, dz_q;
    logic [n-1:0]   a_raw_q;
    logic [n-1:0]   opnd_q;          // multiplicand for mult, divisor for div
    logic [2*n-1:0] acc_q, acc_d;
    logic [n-1:0]   hi_q, lo_q;
    logic           done_q, dz_pulse_q;

    // Operand conditioning at start: magnitudes only for signed ops
    logic         signed_op, a_neg, b_neg;
    logic [n-1:0] a_abs, b_abs;
    assign signed_op = ~op[0];
    assign a_neg     = signed_op & a[n-1];
    assign b_neg     = signed_op & b[n-1];
    assign a_abs     = a_neg ? -a : a;
    assign b_abs     = b_neg ? -b : b;

    // Multiply step: accumulator {partial, multiplier}, add then shift right
    logic [n:0]     mul_sum;
    logic [2*n-1:0] mul_step;
    assign mul_sum  = {1'b0, acc_q[2*n-1:n]} + (acc_q[0] ? {1'b0, opnd_q} : {(n+1){1'b0}});
    assign mul_step = {mul_sum, acc_q[n-1:1]};

    // Divide step: accumulator {remainder, dividend/quotient}, shift left then trial subtract
    logic [n:0]     div_rem;
    logic           div_ge;
    logic [n-1:0]   div_diff;
    logic [2*n-1:0] div_step;
    assign div_rem  = {acc_q[2*n-1:n], acc_q[n-1]};
    assign div_ge   = div_rem >= {1'b0, opnd_q};
    assign div_diff = div_rem[n-1:0] - opnd_q;
    assign div_step = {(div_ge ? div_diff : div_rem[n-1:0]), acc_q[n-2:0], div_ge};

    assign acc_d = is_div_q ? div_step : mul_step;

    // Sign correction applied in FIX
    logic [2*n-1:0] prod_fix;
    logic [n-1:0]   quo_fix, rem_fix;
    assign prod_fix = neg_res_q ? -acc_q : acc_q;
    assign quo_fix  = neg_res_q ? -acc_q[n-1:0] : acc_q[n-1:0];
    assign rem_fix  = neg_rem_q ? -acc_q[2*n-1:n] : acc_q[2*n-1:n];

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            is_div_q   <= 1'b0;
            neg_res_q  <= 1'b0;
            neg_rem_q  <= 1'b0;
            dz_q       <= 1'b0;
            a_raw_q    <= '0;
            opnd_q     <= '0;
            acc_q      <= '0;
            hi_q       <= '0;
            lo_q       <= '0;
            done_q     <= 1'b0;
            dz_pulse_q <= 1'b0;
        end else begin
            done_q     <= 1'b0;
            dz_pulse_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q   <= CALC;
                        cnt_q     <= '0;
                        is_div_q  <= op[1];
                        neg_res_q <= a_neg ^ b_neg;
                        neg_rem_q <= a_neg;
                        dz_q      <= op[1] & (b == '0);
                        a_raw_q   <= a;
                        opnd_q    <= op[1] ? b_abs : a_abs;
                        acc_q     <= {{n{1'b0}}, (op[1] ? a_abs : b_abs)};
                    end else begin
                        if (mthi) hi_q <= wd;
                        if (mtlo) lo_q <= wd;
                    end
                end
                CALC: begin
                    acc_q <= acc_d;
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == CW'(n - 1)) state_q <= FIX;
                end
                FIX: begin
                    state_q <= IDLE;
                    done_q  <= 1'b1;
                    if (dz_q) begin
                        hi_q       <= a_raw_q;
                        lo_q       <= '1;
                        dz_pulse_q <= 1'b1;
                    end else if (is_div_q) begin
                        hi_q <= rem_fix;
                        lo_q <= quo_fix;
                    end else begin
                        hi_q <= prod_fix[2*n-1:n];
                        lo_q <= prod_fix[n-1:0];
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign hi          = hi_q;
    assign lo          = lo_q;
    assign busy        = (state_q != IDLE);
    assign done        = done_q;
    assign div_by_zero = dz_pulse_q;
endmodule

// File: tb/tb_mdu_sequencer.sv
// Directed self-checking bench for mdu_sequencer with hand-computed results.
module tb_mdu_sequencer;
    logic        clk = 1'b0;
    logic        reset, start, mthi, mtlo;
    logic [1:0]  op;
    logic [31:0] a, b, wd;
    logic [31:0] hi, lo;
    logic        busy, done, div_by_zero;

    int n_cmp = 0;
    int n_err = 0;

    mdu_sequencer #(.n(32)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
        .mthi(mthi), .mtlo(mtlo), .wd(wd), .hi(hi), .lo(lo),
        .busy(busy), .done(done), .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic start_op(input logic [1:0] o, input logic [31:0] av, input logic [31:0] bv);
        op = o; a = av; b = bv; start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Counts cycles with busy high (from the cycle after the start edge) and any done pulses seen
    task automatic wait_done(input string tag, output int lat, output int dones);
        lat = 0; dones = 0;
        while (busy && lat < 200) begin
            lat++;
            if (done) dones++;
            tick();
        end
        if (lat >= 200) chk({tag, "_timeout"}, 64'(lat), 64'd0);
    endtask

    task automatic do_op(input string tag, input logic [1:0] o, input logic [31:0] av,
                         input logic [31:0] bv, input logic [31:0] eh, input logic [31:0] el,
                         input logic edz);
        int lat, dones;
        start_op(o, av, bv);
        wait_done(tag, lat, dones);
        chk({tag, "_latency"}, 64'(lat), 64'd33);
        chk({tag, "_done"}, 64'(done), 64'd1);
        chk({tag, "_hi"}, 64'(hi), 64'(eh));
        chk({tag, "_lo"}, 64'(lo), 64'(el));
        chk({tag, "_dz"}, 64'(div_by_zero), 64'(edz));
        $display("txn %s op=%0d a=%h b=%h -> hi=%h lo=%h dz=%0b lat=%0d", tag, o, av, bv, hi, lo, div_by_zero, lat);
        tick();
        chk({tag, "_done_drop"}, 64'(done), 64'd0);
        chk({tag, "_dz_drop"}, 64'(div_by_zero), 64'd0);
    endtask

    initial begin
        int lat, dones, extra;
        reset = 1'b1; start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
        op = 2'b00; a = '0; b = '0; wd = '0;
        tick(); tick();
        reset = 1'b0;
        chk("rst_hi", 64'(hi), 64'd0);
        chk("rst_lo", 64'(lo), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_dz", 64'(div_by_zero), 64'd0);
        $display("txn reset hi=%h lo=%h busy=%0b", hi, lo, busy);

        do_op("multu_max", 2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0);
        do_op("mult_neg",  2'b00, 32'hFFFFFFFD, 32'd5,        32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0);
        do_op("mult_nn",   2'b00, 32'hFFFFFFFE, 32'hFFFFFFF9, 32'h00000000, 32'h0000000E, 1'b0);
        do_op("div_neg",   2'b10, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0);
        do_op("div_negb",  2'b10, 32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0);
        do_op("divu",      2'b11, 32'd7,        32'd2,        32'h00000001, 32'h00000003, 1'b0);
        do_op("div_ovf",   2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0);
        do_op("divu_zero", 2'b11, 32'h00000012, 32'd0,        32'h00000012, 32'hFFFFFFFF, 1'b1);
        do_op("div_zero",  2'b10, 32'hFFFFFFF0, 32'd0,        32'hFFFFFFF0, 32'hFFFFFFFF, 1'b1);

        // start and mthi while busy are both ignored
        start_op(2'b01, 32'd6, 32'd7);
        tick(); tick(); tick(); tick();
        op = 2'b11; a = 32'd100; b = 32'd3; start = 1'b1; mthi = 1'b1; wd = 32'h0000DEAD;
        tick();
        start = 1'b0; mthi = 1'b0;
        wait_done("busy_ign", lat, dones);
        chk("busy_ign_done", 64'(done), 64'd1);
        chk("busy_ign_hi", 64'(hi), 64'd0);
        chk("busy_ign_lo", 64'(lo), 64'd42);
        extra = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (done) extra++;
        end
        chk("busy_ign_one_done", 64'(dones + extra), 64'd0);
        $display("txn busy_ign hi=%h lo=%h extra_dones=%0d", hi, lo, dones + extra);

        // mtlo alone, then both writes together
        mtlo = 1'b1; wd = 32'h00001234;
        tick();
        mtlo = 1'b0;
        chk("mtlo_lo", 64'(lo), 64'h1234);
        chk("mtlo_hi", 64'(hi), 64'd0);
        $display("txn mtlo hi=%h lo=%h", hi, lo);
        mthi = 1'b1; mtlo = 1'b1; wd = 32'h0000A5A5;
        tick();
        mthi = 1'b0; mtlo = 1'b0;
        chk("mtboth_hi", 64'(hi), 64'hA5A5);
        chk("mtboth_lo", 64'(lo), 64'hA5A5);
        $display("txn mthi+mtlo hi=%h lo=%h", hi, lo);

        // start beats mthi on the same edge
        mthi = 1'b1; wd = 32'h0000FFFF;
        start_op(2'b00, 32'd2, 32'd3);
        mthi = 1'b0;
        wait_done("start_mthi", lat, dones);
        chk("start_mthi_lat", 64'(lat), 64'd33);
        chk("start_mthi_hi", 64'(hi), 64'd0);
        chk("start_mthi_lo", 64'(lo), 64'd6);
        $display("txn start+mthi hi=%h lo=%h", hi, lo);
        tick();

        // reset mid-operation aborts without a done pulse
        start_op(2'b11, 32'hFFFFFFFF, 32'd3);
        for (int i = 0; i < 9; i++) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_hi", 64'(hi), 64'd0);
        chk("abort_lo", 64'(lo), 64'd0);
        chk("abort_done", 64'(done), 64'd0);
        extra = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (done) extra++;
        end
        chk("abort_no_done", 64'(extra), 64'd0);
        $display("txn abort busy=%0b hi=%h lo=%h dones=%0d", busy, hi, lo, extra);
        do_op("multu_after", 2'b01, 32'd4, 32'd4, 32'd0, 32'd16, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
